// File: rtl/bp_be_stride_prefetch_gen_if.sv
// Prefetch request channel toward the D$ prefetch port: valid/yumi handshake
// carrying a block-aligned virtual address.
interface bp_be_stride_prefetch_gen_if
    #(parameter int vaddr_width_p = 39);

    logic                     pf_v_o;
    logic [vaddr_width_p-1:0] pf_vaddr_o;
    logic                     pf_yumi_i;

    modport master (output pf_v_o, output pf_vaddr_o, input pf_yumi_i);
    modport slave  (input pf_v_o, input pf_vaddr_o, output pf_yumi_i);

endinterface

// File: rtl/bp_be_stride_prefetch_gen.sv
// Stride prefetch generator: arms on discovery start, triggers on confirm and
// issues a bounded burst of stride-ahead block addresses, dropping same-block repeats.
module bp_be_stride_prefetch_gen
    #(parameter int vaddr_width_p    = 39
    , parameter int stride_width_p   = 8
    , parameter int prefetch_depth_p = 4
    , parameter int block_width_p    = 512)
    (input  logic                      clk_i
    , input  logic                      reset_i
    , input  logic                      stride_v_i
    , input  logic [stride_width_p-1:0] stride_i
    , input  logic [vaddr_width_p-1:0]  pc_i
    , input  logic [vaddr_width_p-1:0]  eff_addr_i
    , input  logic                      start_discovery_i
    , input  logic                      confirm_discovery_i
    , input  logic                      flush_i
    , bp_be_stride_prefetch_gen_if.master pf
    , output logic                      busy_o
    );

    localparam int lg_block_bytes_lp = $clog2(block_width_p/8);
    localparam int blk_width_lp      = vaddr_width_p - lg_block_bytes_lp;
    localparam int k_width_lp        = $clog2(prefetch_depth_p+1);

    typedef enum logic [1:0] {e_idle, e_arm, e_issue} state_e;

    state_e                    state_r, state_n;
    logic [vaddr_width_p-1:0]  arm_pc_r, arm_pc_n;
    logic [vaddr_width_p-1:0]  acc_r, acc_n;
    logic [vaddr_width_p-1:0]  stride_r, stride_n;
    logic [k_width_lp-1:0]     k_r, k_n;
    logic [blk_width_lp-1:0]   last_blk_r, last_blk_n;
    logic                      last_blk_v_r, last_blk_v_n;
    logic                      pend_v_r, pend_v_n;
    logic [vaddr_width_p-1:0]  pend_acc_r, pend_acc_n;
    logic [vaddr_width_p-1:0]  pend_stride_r, pend_stride_n;

    logic [vaddr_width_p-1:0]  stride_sext;
    logic                      rec_start, rec_confirm;
    logic [blk_width_lp-1:0]   cand_blk;
    logic                      skip, accept, step;
    logic                      unused_arm_pc;

    assign stride_sext = {{(vaddr_width_p-stride_width_p){stride_i[stride_width_p-1]}}, stride_i};
    assign rec_start   = stride_v_i & start_discovery_i   & (stride_i != '0);
    assign rec_confirm = stride_v_i & confirm_discovery_i & (stride_i != '0);

    // acc_r always holds base + k*stride for the current step
    assign cand_blk = acc_r[vaddr_width_p-1:lg_block_bytes_lp];
    assign skip     = last_blk_v_r & (cand_blk == last_blk_r);

    assign pf.pf_v_o     = (state_r == e_issue) & ~skip;
    assign pf.pf_vaddr_o = pf.pf_v_o ? {cand_blk, {lg_block_bytes_lp{1'b0}}} : '0;
    assign accept        = pf.pf_v_o & pf.pf_yumi_i;
    assign step          = (state_r == e_issue) & (skip | accept);
    assign busy_o        = (state_r != e_idle);

    assign unused_arm_pc = ^arm_pc_r;

    always_comb begin
        state_n       = state_r;
        arm_pc_n      = arm_pc_r;
        acc_n         = acc_r;
        stride_n      = stride_r;
        k_n           = k_r;
        last_blk_n    = last_blk_r;
        last_blk_v_n  = last_blk_v_r;
        pend_v_n      = pend_v_r;
        pend_acc_n    = pend_acc_r;
        pend_stride_n = pend_stride_r;

        unique case (state_r)
            e_idle: begin
                if (rec_start) begin
                    arm_pc_n = pc_i;
                    state_n  = e_arm;
                end
            end
            e_arm: begin
                if (rec_confirm) begin
                    acc_n        = eff_addr_i + stride_sext;
                    stride_n     = stride_sext;
                    k_n          = k_width_lp'(1);
                    last_blk_v_n = 1'b0;
                    state_n      = e_issue;
                end else if (rec_start) begin
                    arm_pc_n = pc_i;
                end
            end
            e_issue: begin
                if (accept) begin
                    last_blk_n   = cand_blk;
                    last_blk_v_n = 1'b1;
                end
                // A restart is only applied on a step; while stalled the newest confirm waits
                if (step) begin
                    if (rec_confirm) begin
                        acc_n    = eff_addr_i + stride_sext;
                        stride_n = stride_sext;
                        k_n      = k_width_lp'(1);
                        pend_v_n = 1'b0;
                    end else if (pend_v_r) begin
                        acc_n    = pend_acc_r;
                        stride_n = pend_stride_r;
                        k_n      = k_width_lp'(1);
                        pend_v_n = 1'b0;
                    end else if (k_r == k_width_lp'(prefetch_depth_p)) begin
                        k_n     = '0;
                        state_n = e_idle;
                    end else begin
                        acc_n = acc_r + stride_r;
                        k_n   = k_r + k_width_lp'(1);
                    end
                end else if (rec_confirm) begin
                    pend_v_n      = 1'b1;
                    pend_acc_n    = eff_addr_i + stride_sext;
                    pend_stride_n = stride_sext;
                end
            end
            default: state_n = e_idle;
        endcase

        if (flush_i) begin
            state_n  = e_idle;
            pend_v_n = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r       <= e_idle;
            arm_pc_r      <= '0;
            acc_r         <= '0;
            stride_r      <= '0;
            k_r           <= '0;
            last_blk_r    <= '0;
            last_blk_v_r  <= 1'b0;
            pend_v_r      <= 1'b0;
            pend_acc_r    <= '0;
            pend_stride_r <= '0;
        end else begin
            state_r       <= state_n;
            arm_pc_r      <= arm_pc_n;
            acc_r         <= acc_n;
            stride_r      <= stride_n;
            k_r           <= k_n;
            last_blk_r    <= last_blk_n;
            last_blk_v_r  <= last_blk_v_n;
            pend_v_r      <= pend_v_n;
            pend_acc_r    <= pend_acc_n;
            pend_stride_r <= pend_stride_n;
        end
    end

endmodule

// File: tb/tb_bp_be_stride_prefetch_gen.sv
// Bench for the stride prefetch generator: directed scenarios plus random
// traffic, all compared cycle by cycle against a burst-level reference model.
module tb_bp_be_stride_prefetch_gen;

    localparam int W     = 39;
    localparam int DEPTH = 4;
    localparam int LG    = 6;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic          stride_v_i;
    logic [7:0]    stride_i;
    logic [W-1:0]  pc_i;
    logic [W-1:0]  eff_addr_i;
    logic          start_discovery_i;
    logic          confirm_discovery_i;
    logic          flush_i;
    logic          busy_o;

    bp_be_stride_prefetch_gen_if #(.vaddr_width_p(W)) pf_if ();

    bp_be_stride_prefetch_gen #(
        .vaddr_width_p(W), .stride_width_p(8),
        .prefetch_depth_p(DEPTH), .block_width_p(512)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i), .stride_v_i(stride_v_i), .stride_i(stride_i),
        .pc_i(pc_i), .eff_addr_i(eff_addr_i), .start_discovery_i(start_discovery_i),
        .confirm_discovery_i(confirm_discovery_i), .flush_i(flush_i),
        .pf(pf_if.master), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // Reference model: a burst is (base, stride, k); candidate = base + k*stride.
    logic         m_armed, m_active;
    logic [W-1:0] m_base, m_stride, m_last_blk, m_pend_base, m_pend_stride;
    logic         m_last_v, m_pend_v;
    int           m_k;
    logic         exp_v, exp_busy;
    logic [W-1:0] exp_addr, exp_blk;
    logic         obs_v, obs_busy;
    logic [W-1:0] obs_addr;

    function automatic logic [W-1:0] sx(input logic [7:0] s);
        return {{(W-8){s[7]}}, s};
    endfunction

    task automatic model_reset();
        m_armed = 0; m_active = 0; m_base = '0; m_stride = '0; m_k = 0;
        m_last_v = 0; m_last_blk = '0; m_pend_v = 0; m_pend_base = '0; m_pend_stride = '0;
    endtask

    task automatic model_outputs();
        logic [W-1:0] cand;
        cand     = m_base + W'(m_k) * m_stride;
        exp_blk  = cand >> LG;
        exp_v    = m_active && !(m_last_v && exp_blk == m_last_blk);
        exp_addr = exp_v ? (exp_blk << LG) : '0;
        exp_busy = m_armed || m_active;
    endtask

    task automatic model_step(input logic sv, input logic [7:0] s, input logic [W-1:0] eff,
                              input logic st, input logic cf, input logic fl, input logic y);
        logic ok, conf, strt, acc;
        ok   = sv && (s != 0);
        conf = ok && cf;
        strt = ok && st;
        if (fl) begin
            m_armed = 0; m_active = 0; m_pend_v = 0;
        end else if (m_active) begin
            acc = exp_v && y;
            if (acc) begin m_last_v = 1; m_last_blk = exp_blk; end
            if (!exp_v || acc) begin
                if (conf) begin
                    m_base = eff; m_stride = sx(s); m_k = 1; m_pend_v = 0;
                end else if (m_pend_v) begin
                    m_base = m_pend_base; m_stride = m_pend_stride; m_k = 1; m_pend_v = 0;
                end else if (m_k == DEPTH) m_active = 0;
                else m_k++;
            end else if (conf) begin
                m_pend_v = 1; m_pend_base = eff; m_pend_stride = sx(s);
            end
        end else if (m_armed) begin
            if (conf) begin
                m_armed = 0; m_active = 1; m_base = eff; m_stride = sx(s);
                m_k = 1; m_last_v = 0;
            end
        end else if (strt) m_armed = 1;
    endtask

    // Called at posedge+1: drive, check at negedge, advance the model on the next posedge.
    task automatic cyc(input logic sv, input logic [7:0] s, input logic [W-1:0] pc,
                       input logic [W-1:0] eff, input logic st, input logic cf,
                       input logic fl, input logic y);
        stride_v_i = sv; stride_i = s; pc_i = pc; eff_addr_i = eff;
        start_discovery_i = st; confirm_discovery_i = cf; flush_i = fl; pf_if.pf_yumi_i = y;
        #4;
        model_outputs();
        obs_v = pf_if.pf_v_o; obs_addr = pf_if.pf_vaddr_o; obs_busy = busy_o;
        check("pf_v",     64'(obs_v),    64'(exp_v));
        check("pf_vaddr", 64'(obs_addr), 64'(exp_addr));
        check("busy",     64'(obs_busy), 64'(exp_busy));
        @(posedge clk_i);
        model_step(sv, s, eff, st, cf, fl, y);
        #1;
    endtask

    task automatic idle(input logic y);
        cyc(0, 8'h00, '0, '0, 0, 0, 0, y);
    endtask

    task automatic start(input logic [W-1:0] pc, input logic [7:0] s);
        cyc(1, s, pc, '0, 1, 0, 0, 0);
    endtask

    task automatic confirm(input logic [W-1:0] eff, input logic [7:0] s, input logic y);
        cyc(1, s, '0, eff, 0, 1, 0, y);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset_i = 1; stride_v_i = 0; stride_i = '0; pc_i = '0; eff_addr_i = '0;
        start_discovery_i = 0; confirm_discovery_i = 0; flush_i = 0; pf_if.pf_yumi_i = 0;
        model_reset();
        @(posedge clk_i); #1;
        check("reset_v",     64'(pf_if.pf_v_o),     64'(0));
        check("reset_vaddr", 64'(pf_if.pf_vaddr_o), 64'(0));
        check("reset_busy",  64'(busy_o),           64'(0));
        reset_i = 0;
        idle(1);

        // basic burst, yumi held high
        start(39'h1000, 8'd64);
        confirm(39'h8000, 8'd64, 1);
        for (int i = 1; i <= DEPTH; i++) begin
            idle(1);
            check("burst_addr", 64'(obs_addr), 64'(39'h8000 + 39'(64*i)));
        end
        idle(1);
        check("burst_done", 64'(obs_busy), 64'(0));

        // same-block dedup
        start(39'h1000, 8'd8);
        confirm(39'h8000, 8'd8, 1);
        idle(1);
        check("dedup_first", 64'(obs_addr), 64'(39'h8000));
        for (int i = 0; i < 3; i++) begin
            idle(1);
            check("dedup_skip", 64'({obs_v, obs_busy}), 64'(2'b01));
        end
        idle(1);
        check("dedup_done", 64'(obs_busy), 64'(0));

        // negative stride wrapping at the address width
        start(39'h1000, 8'hC0);
        confirm(39'h20, 8'hC0, 1);
        idle(1);
        check("neg_first", 64'(obs_addr), 64'(39'h7F_FFFF_FFC0));
        idle(1);
        check("neg_second", 64'(obs_addr), 64'(39'h7F_FFFF_FF80));
        repeat (4) idle(1);

        // backpressure with a restart confirm arriving mid-stall
        start(39'h1000, 8'd64);
        confirm(39'h8000, 8'd64, 0);
        idle(0);
        confirm(39'h9000, 8'd64, 0);
        check("stall_addr", 64'(obs_addr), 64'(39'h8040));
        repeat (3) idle(0);
        check("stall_hold", 64'({obs_v, obs_addr}), 64'({1'b1, 39'h8040}));
        idle(1);
        idle(1);
        check("restart_addr", 64'(obs_addr), 64'(39'h9040));
        repeat (6) idle(1);

        // flush retracts an unaccepted request; a bare confirm afterwards is ignored
        start(39'h1000, 8'd64);
        confirm(39'h8000, 8'd64, 0);
        idle(0);
        cyc(0, 8'h00, '0, '0, 0, 0, 1, 0);
        idle(0);
        check("flush_v",    64'(obs_v),    64'(0));
        check("flush_busy", 64'(obs_busy), 64'(0));
        confirm(39'hA000, 8'd64, 1);
        idle(1);
        check("flush_noconf", 64'(obs_busy), 64'(0));

        // asynchronous reset between clock edges during a request
        start(39'h1000, 8'd64);
        confirm(39'h8000, 8'd64, 0);
        idle(0);
        check("pre_reset_v", 64'(obs_v), 64'(1));
        stride_v_i = 0; start_discovery_i = 0; confirm_discovery_i = 0;
        flush_i = 0; pf_if.pf_yumi_i = 0;
        #2 reset_i = 1;
        #1;
        check("areset_v",     64'(pf_if.pf_v_o),     64'(0));
        check("areset_vaddr", 64'(pf_if.pf_vaddr_o), 64'(0));
        check("areset_busy",  64'(busy_o),           64'(0));
        model_reset();
        #1 reset_i = 0;
        @(posedge clk_i); #1;
        idle(1);

        // random traffic against the model
        for (int n = 0; n < 2000; n++) begin
            logic [7:0] s;
            logic [W-1:0] pc, eff;
            case ($urandom % 6)
                0: s = 8'h00;
                1: s = 8'd8;
                2: s = 8'd64;
                3: s = 8'hC0;
                4: s = 8'h80;
                default: s = 8'($urandom);
            endcase
            pc  = W'({$urandom, $urandom});
            eff = W'({$urandom, $urandom});
            cyc(($urandom % 8) != 0, s, pc, eff, ($urandom % 4) == 0, ($urandom % 3) == 0,
                ($urandom % 40) == 0, ($urandom % 2) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
